// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single user port of the SDRAM controller between a burst-write
//   requester (capture side) and a burst-read requester (display side).
//   Round-robin arbitration, one command/data handshake per burst.
//
//   state | meaning
//   IDLE  | no transaction, arbitrate pending requests
//   CMD   | ctrl_cmd_vld held until the controller takes the command
//   XFER  | data phase, words flow until ctrl_done
//   DONE  | done pulse for the owning port, grant dropped
//   GAP   | mandatory idle cycle, also arbitrates a request still held
//
// Ports
//   sys_clk, sys_rst_n             clock, async active-low reset
//   wr_req/addr/len, wr_grant      write port request and grant
//   wr_data, wr_data_rd, wr_done   write source word, pop strobe, done pulse
//   rd_req/addr/len, rd_grant      read port request and grant
//   rd_data, rd_data_vld, rd_done  registered read word, valid, done pulse
//   ctrl_cmd_*                     command handshake to the controller
//   ctrl_wdata_req, ctrl_wdata     controller write data pull
//   ctrl_rdata, ctrl_rdata_vld     controller read data
//   ctrl_done                      controller end-of-burst pulse
module sdram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_grant,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_rd,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic              rd_done,
  output logic              ctrl_cmd_vld,
  input  logic              ctrl_cmd_rdy,
  output logic              ctrl_cmd_we,
  output logic [ADDR_W-1:0] ctrl_cmd_addr,
  output logic [LEN_W-1:0]  ctrl_cmd_len,
  input  logic              ctrl_wdata_req,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic [DATA_W-1:0] ctrl_rdata,
  input  logic              ctrl_rdata_vld,
  input  logic              ctrl_done
);

  typedef enum logic [2:0] {IDLE, CMD, XFER, DONE, GAP} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            state, state_nx;
  logic              last_wr;
  logic [LEN_W-1:0]  word_cnt;
  logic              arb_wr, arb_rd, launch;
  logic [LEN_W-1:0]  sel_len;
  logic              busy, xfer_wr, xfer_rd, room, rd_beat;

  // last_wr = 0 after reset means read was last, so write wins the first tie
  assign arb_wr  = wr_req && (!rd_req || !last_wr);
  assign arb_rd  = rd_req && !arb_wr;
  // GAP arbitrates as well: a held request gets its new command 3 cycles
  // after ctrl_done while still leaving DONE+GAP idle between bursts
  assign launch  = ((state == IDLE) || (state == GAP)) && (arb_wr || arb_rd);
  assign sel_len = arb_wr ? wr_len : rd_len;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = CMD;
      CMD:     if (ctrl_cmd_rdy) state_nx = XFER;
      XFER:    if (ctrl_done) state_nx = DONE;
      DONE:    state_nx = GAP;
      GAP:     state_nx = launch ? CMD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state == CMD) || (state == XFER);
  assign xfer_wr = (state == XFER) && ctrl_cmd_we;
  assign xfer_rd = (state == XFER) && !ctrl_cmd_we;
  // never pop or forward more words than the burst asked for
  assign room    = (word_cnt != ctrl_cmd_len);
  assign rd_beat = xfer_rd && ctrl_rdata_vld && room;

  assign wr_grant     = busy && ctrl_cmd_we;
  assign rd_grant     = busy && !ctrl_cmd_we;
  assign ctrl_cmd_vld = (state == CMD);
  assign wr_data_rd   = xfer_wr && ctrl_wdata_req && room;
  assign ctrl_wdata   = xfer_wr ? wr_data : '0;
  assign wr_done      = (state == DONE) && ctrl_cmd_we;
  assign rd_done      = (state == DONE) && !ctrl_cmd_we;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      last_wr       <= 1'b0;
      ctrl_cmd_we   <= 1'b0;
      ctrl_cmd_addr <= '0;
      ctrl_cmd_len  <= '0;
      word_cnt      <= '0;
      rd_data       <= '0;
      rd_data_vld   <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        ctrl_cmd_we   <= arb_wr;
        ctrl_cmd_addr <= arb_wr ? wr_addr : rd_addr;
        ctrl_cmd_len  <= (sel_len == '0) ? LEN_ONE : sel_len;
        word_cnt      <= '0;
      end else if (wr_data_rd || rd_beat) begin
        word_cnt <= word_cnt + LEN_ONE;
      end
      if (state == DONE) last_wr <= ctrl_cmd_we;
      rd_data_vld <= rd_beat;
      if (rd_beat) rd_data <= ctrl_rdata;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed write table, hand sequences for
// read, tie, late request, reset and zero length, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [LEN_W-1:0]  wr_len, rd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_grant, wr_data_rd, wr_done;
  logic              rd_grant, rd_data_vld, rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              ctrl_cmd_vld, ctrl_cmd_rdy, ctrl_cmd_we;
  logic [ADDR_W-1:0] ctrl_cmd_addr;
  logic [LEN_W-1:0]  ctrl_cmd_len;
  logic              ctrl_wdata_req;
  logic [DATA_W-1:0] ctrl_wdata;
  logic [DATA_W-1:0] ctrl_rdata;
  logic              ctrl_rdata_vld, ctrl_done;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_grant(wr_grant),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_done(rd_done),
    .ctrl_cmd_vld(ctrl_cmd_vld), .ctrl_cmd_rdy(ctrl_cmd_rdy), .ctrl_cmd_we(ctrl_cmd_we),
    .ctrl_cmd_addr(ctrl_cmd_addr), .ctrl_cmd_len(ctrl_cmd_len),
    .ctrl_wdata_req(ctrl_wdata_req), .ctrl_wdata(ctrl_wdata),
    .ctrl_rdata(ctrl_rdata), .ctrl_rdata_vld(ctrl_rdata_vld), .ctrl_done(ctrl_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: who owns the controller, whether its command was taken,
  // which done pulse is showing, and the latched command fields
  int                m_owner;   // 0 none, 1 write, 2 read
  bit                m_acc;
  int                m_pulse;   // 0 none, 1 write done, 2 read done
  bit                m_last_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  bit                m_we;
  logic [DATA_W-1:0] m_rdata;
  bit                m_rvld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_acc = 0; m_pulse = 0; m_last_wr = 0;
    m_addr = '0; m_len = '0; m_we = 0; m_rdata = '0; m_rvld = 0;
  endtask

  task automatic model_step();
    bit rv;
    rv = (m_owner == 2) && m_acc && ctrl_rdata_vld;
    if (rv) m_rdata = ctrl_rdata;
    m_rvld = rv;
    if (m_owner != 0 && !m_acc) begin
      if (ctrl_cmd_rdy) m_acc = 1;
    end else if (m_owner != 0) begin
      if (ctrl_done) begin
        m_pulse = m_owner; m_last_wr = (m_owner == 1); m_owner = 0; m_acc = 0;
      end
    end else if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (wr_req && (!rd_req || !m_last_wr)) begin
      m_owner = 1; m_we = 1; m_addr = wr_addr;
      m_len = (wr_len == 0) ? LEN_W'(1) : wr_len;
    end else if (rd_req) begin
      m_owner = 2; m_we = 0; m_addr = rd_addr;
      m_len = (rd_len == 0) ? LEN_W'(1) : rd_len;
    end
  endtask

  task automatic check_model();
    bit wx;
    wx = (m_owner == 1) && m_acc;
    chk("wr_grant", wr_grant, m_owner == 1);
    chk("rd_grant", rd_grant, m_owner == 2);
    chk("grant_excl", wr_grant & rd_grant, 0);
    chk("cmd_vld", ctrl_cmd_vld, (m_owner != 0) && !m_acc);
    chk("cmd_we", ctrl_cmd_we, m_we);
    chk("cmd_addr", ctrl_cmd_addr, m_addr);
    chk("cmd_len", ctrl_cmd_len, m_len);
    chk("wr_data_rd", wr_data_rd, wx && ctrl_wdata_req);
    chk("ctrl_wdata", ctrl_wdata, wx ? wr_data : '0);
    chk("wr_done", wr_done, m_pulse == 1);
    chk("rd_done", rd_done, m_pulse == 2);
    chk("rd_data", rd_data, m_rdata);
    chk("rd_data_vld", rd_data_vld, m_rvld);
  endtask

  // inputs are set just after a falling edge; check, then advance one clock
  task automatic cyc();
    #1;
    check_model();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic clear_inputs();
    wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    wr_data = '0; ctrl_cmd_rdy = 0; ctrl_wdata_req = 0; ctrl_rdata = '0;
    ctrl_rdata_vld = 0; ctrl_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst_n = 0;
    model_reset();
    @(negedge sys_clk);
    #1 check_model();
    @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  task automatic rand_reqs();
    if ($urandom_range(0, 2) == 0) wr_req = ~wr_req;
    if ($urandom_range(0, 2) == 0) rd_req = ~rd_req;
    if (!wr_req && !rd_req) wr_req = 1;
    wr_addr = ADDR_W'($urandom);
    rd_addr = ADDR_W'($urandom);
    wr_len  = LEN_W'($urandom_range(0, 5));
    rd_len  = LEN_W'($urandom_range(0, 5));
    wr_data = DATA_W'($urandom);
  endtask

  // plays the controller for one burst, starting from wherever the next
  // command will appear; stops right after the ctrl_done cycle
  task automatic serve(input int rdy_dly, input bit rnd);
    int w, len, sent;
    bit dir_wr;
    w = 0;
    while (!ctrl_cmd_vld && w < 20) begin
      if (rnd) rand_reqs();
      cyc();
      w++;
    end
    if (!ctrl_cmd_vld) begin
      chk("cmd_wait", ctrl_cmd_vld, 1);
      return;
    end
    dir_wr = (m_owner == 1);
    len = int'(m_len);
    for (int i = 0; i < rdy_dly; i++) begin
      if (rnd) rand_reqs();
      cyc();
    end
    ctrl_cmd_rdy = 1;
    cyc();
    ctrl_cmd_rdy = 0;
    sent = 0;
    while (sent < len) begin
      if (rnd) rand_reqs();
      wr_data = DATA_W'($urandom);
      ctrl_rdata = DATA_W'($urandom);
      if (rnd && $urandom_range(0, 2) == 0) begin
        ctrl_wdata_req = 0; ctrl_rdata_vld = 0;
      end else begin
        ctrl_wdata_req = dir_wr ? 1'b1 : (rnd && $urandom_range(0, 1) == 1);
        ctrl_rdata_vld = dir_wr ? (rnd && $urandom_range(0, 1) == 1) : 1'b1;
        sent++;
      end
      cyc();
    end
    ctrl_wdata_req = 0; ctrl_rdata_vld = 0;
    ctrl_done = 1;
    cyc();
    ctrl_done = 0;
  endtask

  // cycles from the ctrl_done cycle to the next ctrl_cmd_vld
  task automatic gap_to_cmd(output int g);
    g = 1;
    while (!ctrl_cmd_vld && g < 8) begin
      cyc();
      g++;
    end
  endtask

  typedef struct {
    bit wr_req, rdy, wreq, cdone;
    bit e_wg, e_cvld, e_we, e_wdrd, e_wdone;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit wq, input bit ry, input bit wdq, input bit cd,
                     input bit wg, input bit cv, input bit we, input bit wdr, input bit wdn);
    vec_t v;
    v.wr_req = wq; v.rdy = ry; v.wreq = wdq; v.cdone = cd;
    v.e_wg = wg; v.e_cvld = cv; v.e_we = we; v.e_wdrd = wdr; v.e_wdone = wdn;
    vecs.push_back(v);
  endtask

  initial begin
    int g;
    bit first_wr;
    model_reset();
    clear_inputs();

    // single write, addr 0x100 len 8: request, two stalled command cycles,
    // accept, 8 pulls, ctrl_done, done pulse, gap, idle
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(1, 1, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);

    do_reset();
    wr_addr = 24'h000100; wr_len = 10'd8;
    foreach (vecs[i]) begin
      wr_req = vecs[i].wr_req; ctrl_cmd_rdy = vecs[i].rdy;
      ctrl_wdata_req = vecs[i].wreq; ctrl_done = vecs[i].cdone;
      wr_data = DATA_W'(16'h3000 + i);
      #1;
      chk($sformatf("tbl%0d_wr_grant", i), wr_grant, vecs[i].e_wg);
      chk($sformatf("tbl%0d_cmd_vld", i), ctrl_cmd_vld, vecs[i].e_cvld);
      chk($sformatf("tbl%0d_cmd_we", i), ctrl_cmd_we, vecs[i].e_we);
      chk($sformatf("tbl%0d_wr_data_rd", i), wr_data_rd, vecs[i].e_wdrd);
      chk($sformatf("tbl%0d_wr_done", i), wr_done, vecs[i].e_wdone);
      if (vecs[i].e_cvld) begin
        chk("tbl_cmd_addr", ctrl_cmd_addr, 24'h000100);
        chk("tbl_cmd_len", ctrl_cmd_len, 10'd8);
      end
      cyc();
    end
    clear_inputs();

    // single read, addr 0x1000 len 4, data 0xA5A0..0xA5A3
    rd_req = 1; rd_addr = 24'h001000; rd_len = 10'd4;
    cyc();
    rd_req = 0;
    chk("rd_cmd_we", ctrl_cmd_we, 0);
    chk("rd_cmd_addr", ctrl_cmd_addr, 24'h001000);
    chk("rd_cmd_len", ctrl_cmd_len, 10'd4);
    ctrl_cmd_rdy = 1;
    cyc();
    ctrl_cmd_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      ctrl_rdata = DATA_W'(16'hA5A0 + i); ctrl_rdata_vld = 1;
      ctrl_wdata_req = 1;
      cyc();
      chk("rd_seq_data", rd_data, 16'hA5A0 + i);
      chk("rd_seq_vld", rd_data_vld, 1);
    end
    ctrl_rdata_vld = 0; ctrl_wdata_req = 0; ctrl_done = 1;
    cyc();
    ctrl_done = 0;
    chk("rd_done_pulse", rd_done, 1);
    chk("rd_grant_at_done", rd_grant, 0);
    cyc();
    chk("rd_done_once", rd_done, 0);
    cyc();

    // tie after reset: write, read, write, read with 3-cycle turnaround
    do_reset();
    wr_req = 1; rd_req = 1; wr_len = 10'd2; rd_len = 10'd3;
    wr_addr = 24'h00ABCD; rd_addr = 24'h00DCBA;
    for (int i = 0; i < 4; i++) begin
      if (!ctrl_cmd_vld) cyc();
      chk($sformatf("tie%0d_wr_grant", i), wr_grant, (i % 2) == 0);
      chk($sformatf("tie%0d_rd_grant", i), rd_grant, (i % 2) == 1);
      serve(1, 0);
      if (i < 3) begin
        gap_to_cmd(g);
        chk($sformatf("tie%0d_turnaround", i), g, 3);
      end
    end
    clear_inputs();
    repeat (3) cyc();

    // late request: read rises after the write is granted
    wr_req = 1; wr_len = 10'd4;
    cyc();
    wr_req = 0; rd_req = 1; rd_len = 10'd2;
    serve(2, 0);
    chk("late_rd_wait", rd_grant, 0);
    gap_to_cmd(g);
    chk("late_turnaround", g, 3);
    chk("late_rd_grant", rd_grant, 1);
    rd_req = 0;
    serve(0, 0);
    repeat (3) cyc();

    // reset in the middle of a len 16 read
    rd_req = 1; rd_len = 10'd16; rd_addr = 24'h055555;
    cyc();
    rd_req = 0; ctrl_cmd_rdy = 1;
    cyc();
    ctrl_cmd_rdy = 0; ctrl_rdata_vld = 1; ctrl_rdata = 16'h1234;
    cyc();
    cyc();
    chk("pre_rst_vld", rd_data_vld, 1);
    sys_rst_n = 0;
    model_reset();
    #1;
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_vld", rd_data_vld, 0);
    chk("rst_cmd_addr", ctrl_cmd_addr, 0);
    chk("rst_cmd_len", ctrl_cmd_len, 0);
    chk("rst_rd_done", rd_done, 0);
    clear_inputs();
    @(negedge sys_clk);
    sys_rst_n = 1;
    cyc();
    chk("post_rst_no_done", rd_done, 0);
    wr_req = 1; rd_req = 1; wr_len = 10'd1; rd_len = 10'd1;
    cyc();
    chk("post_rst_tie_wr", wr_grant, 1);
    wr_req = 0; rd_req = 0;
    serve(0, 0);
    repeat (3) cyc();

    // zero length write goes out as length 1
    wr_req = 1; wr_len = 10'd0; wr_addr = 24'h000777;
    cyc();
    wr_req = 0;
    chk("len0_cmd_len", ctrl_cmd_len, 1);
    serve(0, 0);
    repeat (3) cyc();

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) serve($urandom_range(0, 3), 1);
    clear_inputs();
    repeat (4) cyc();

    first_wr = 0;
    if (first_wr) chk("unused", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter between the streaming requesters and the single user port of the SDRAM controller in the 100 MHz Qsys clock domain. It shares the controller between a burst-write port (capture side) and a burst-read port (display side), and sequences each transaction through a command/data handshake. Arbitration is round-robin so neither port can starve the other. The block issues SDRAM traffic only; refresh and timing belong to the controller.

## Interface
Parameters:
- ADDR_W, 24, SDRAM word address width
- DATA_W, 16, data width, matching the 16-bit SDRAM bus
- LEN_W, 10, burst length field width, in words

Ports:
- sys_clk  in  1  system clock; every register is on the rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write port request, level
- wr_addr  in  ADDR_W  write start address
- wr_len  in  LEN_W  write burst length
- wr_grant  out  1  write port owns the controller
- wr_data  in  DATA_W  write data word
- wr_data_rd  out  1  pops one word from the write source
- wr_done  out  1  one-cycle pulse when the write burst completes
- rd_req  in  1  read port request, level
- rd_addr  in  ADDR_W  read start address
- rd_len  in  LEN_W  read burst length
- rd_grant  out  1  read port owns the controller
- rd_data  out  DATA_W  registered read data
- rd_data_vld  out  1  rd_data valid
- rd_done  out  1  one-cycle pulse when the read burst completes
- ctrl_cmd_vld  out  1  command valid
- ctrl_cmd_rdy  in  1  controller accepts the command
- ctrl_cmd_we  out  1  1 = write, 0 = read
- ctrl_cmd_addr  out  ADDR_W  latched start address
- ctrl_cmd_len  out  LEN_W  latched burst length
- ctrl_wdata_req  in  1  controller takes a write word this cycle
- ctrl_wdata  out  DATA_W  write word sent to the controller
- ctrl_rdata  in  DATA_W  read word from the controller
- ctrl_rdata_vld  in  1  ctrl_rdata valid
- ctrl_done  in  1  one-cycle pulse at the end of the controller burst

## Operation
- States: IDLE, CMD, XFER, DONE, GAP.
- IDLE
  - Only one request pending: grant it.
  - Both pending: grant the port opposite to last_grant.
  - Neither pending: stay in IDLE.
  - On grant: latch addr/len and set ctrl_cmd_we, then go to CMD.
- CMD: hold ctrl_cmd_vld high with stable addr/len/we until ctrl_cmd_rdy; the cycle with vld & rdy moves to XFER.
- XFER, write
  - wr_data_rd = ctrl_wdata_req (combinational).
  - ctrl_wdata = wr_data (combinational).
- XFER, read
  - rd_data and rd_data_vld are ctrl_rdata and ctrl_rdata_vld registered by one cycle.
- XFER, both directions: an internal word counter counts transferred words; ctrl_done moves to DONE.
- DONE: pulse wr_done or rd_done for one cycle, drop the grant, update last_grant, then go to GAP.
- GAP: one idle cycle, then IDLE. This guarantees at least one cycle between commands.
- len = 0 is illegal; it is sent to the controller as 1.
- A request that drops during CMD or XFER is ignored; the transaction runs to ctrl_done.
- rd_data_vld while granted to write is suppressed. ctrl_wdata_req while granted to read does not pop wr_data.

## Timing
- Reset values:
  - state IDLE, last_grant = read (write wins the first tie)
  - every output 0, including addr/len/data registers
- Latency:
  - request sampled in IDLE → grant and ctrl_cmd_vld both high the next cycle
  - ctrl_done → done pulse the next cycle; grant low in that same cycle
  - read data: ctrl_rdata_vld → rd_data_vld 1 cycle later
- Turnaround: done pulse, then GAP, then IDLE. A request still held is regranted 3 cycles after ctrl_done, i.e. a new ctrl_cmd_vld 3 cycles after ctrl_done.
- Grants are mutually exclusive and never both high.
- A request asserted during another port's transaction waits for GAP → IDLE and then wins by round-robin.
- Reset asserted mid-transaction clears everything immediately, with no done pulse.

## Test plan
- Single write: wr_req with addr 0x000100, len 8; rdy after 2 cycles; 8 wdata_req, then ctrl_done. Required: ctrl_cmd_we=1, 8 wr_data_rd pulses, wr_done 1 cycle after ctrl_done.
- Single read: rd_req with addr 0x001000, len 4; controller returns 0xA5A0..0xA5A3. Required: rd_data shows the same sequence 1 cycle delayed; rd_done pulses once.
- Tie after reset: wr_req and rd_req high together and held. Required: grant order write, read, write, read; ctrl_cmd_vld edges 3 cycles after each ctrl_done.
- Late request: rd_req rises mid-write. Required: no rd_grant until the write's GAP; then read is granted.
- Reset mid-op: sys_rst_n low during XFER of a len 16 read. Required: all outputs 0, no rd_done; after release, IDLE and the first tie goes to write.
- len = 0 write. Required: ctrl_cmd_len = 1.
